// File: rtl/status_stack.sv
// Nesting status register: a live status word plus a LIFO of saved words.
// Exception entry pushes and masks the live word; exception return pops it back.
module status_stack #(
  parameter int                 WIDTH     = 32,
  parameter int                 DEPTH     = 4,
  parameter int                 MASK_BITS = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                       Clk,
  input  logic                       Clrn,
  input  logic [WIDTH-1:0]           Qb,
  input  logic                       Wsta,
  input  logic                       Exc,
  input  logic                       Eret,
  input  logic                       Clr_err,
  output logic [WIDTH-1:0]           sta,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Ones in the interrupt-enable field; cleared from sta on exception entry.
  localparam logic [WIDTH-1:0] LOW_ONES  = {WIDTH{1'b1}} >> (WIDTH - MASK_BITS);
  localparam logic [WIDTH-1:0] KEEP_MASK = ~LOW_ONES;
  localparam logic [DW-1:0]    DEPTH_MAX = DW'(DEPTH);

  logic [WIDTH-1:0] sta_q, sta_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             full_w;
  logic             empty_w;
  logic             do_exc, do_eret, do_wsta;
  logic             push, pop, ovf_set, unf_set;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic [DW-1:0]    depth_m1;

  assign full_w   = (depth_q == DEPTH_MAX);
  assign empty_w  = (depth_q == '0);
  assign depth_m1 = depth_q - DW'(1);
  assign push_idx = depth_q[AW-1:0];
  assign pop_idx  = depth_m1[AW-1:0];

  // Exc > Eret > Wsta: only the highest active command has any effect.
  assign do_exc  = Exc;
  assign do_eret = Eret & ~Exc;
  assign do_wsta = Wsta & ~Exc & ~Eret;

  assign push    = do_exc & ~full_w;
  assign ovf_set = do_exc & full_w;
  assign pop     = do_eret & ~empty_w;
  assign unf_set = do_eret & empty_w;

  always_comb begin
    sta_d   = sta_q;
    depth_d = depth_q;
    if (do_exc) begin
      sta_d = sta_q & KEEP_MASK;
      if (push) depth_d = depth_q + DW'(1);
    end else if (pop) begin
      sta_d   = stack_q[pop_idx];
      depth_d = depth_m1;
    end else if (do_wsta) begin
      sta_d = Qb;
    end
  end

  // A new error in the same cycle as Clr_err still sets the flag.
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~Clr_err);
    unf_d = unf_set | (unf_q & ~Clr_err);
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      sta_q   <= RESET_VAL;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sta_q   <= sta_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are unreadable until pushed, so they need no reset.
  always_ff @(posedge Clk) begin
    if (push) stack_q[push_idx] <= sta_q;
  end

  assign sta   = sta_q;
  assign depth = depth_q;
  assign full  = full_w;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_status_stack.sv
// Directed bench for status_stack (WIDTH=32, DEPTH=4, MASK_BITS=4, RESET_VAL=0).
module tb_status_stack;

  logic        Clk;
  logic        Clrn;
  logic [31:0] Qb;
  logic        Wsta, Exc, Eret, Clr_err;
  logic [31:0] sta;
  logic [2:0]  depth;
  logic        full, ovf, unf;

  int checks;
  int errors;

  status_stack #(
    .WIDTH(32), .DEPTH(4), .MASK_BITS(4), .RESET_VAL(32'h0)
  ) dut (
    .Clk(Clk), .Clrn(Clrn), .Qb(Qb), .Wsta(Wsta), .Exc(Exc), .Eret(Eret),
    .Clr_err(Clr_err), .sta(sta), .depth(depth), .full(full), .ovf(ovf), .unf(unf)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one command for one rising edge; returns on the following negedge.
  task automatic step(input logic exc, input logic eret, input logic wsta,
                      input logic clr, input logic [31:0] qb);
    Exc = exc; Eret = eret; Wsta = wsta; Clr_err = clr; Qb = qb;
    @(posedge Clk);
    @(negedge Clk);
    Exc = 1'b0; Eret = 1'b0; Wsta = 1'b0; Clr_err = 1'b0; Qb = '0;
  endtask

  task automatic test_reset();
    Clrn = 1'b0; Exc = 0; Eret = 0; Wsta = 0; Clr_err = 0; Qb = '0;
    repeat (2) @(negedge Clk);
    checks++;
    if (sta !== 32'h0 || depth !== 3'd0 || full !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
      errors++;
      $display("FAIL reset: sta=%h depth=%0d full=%b ovf=%b unf=%b, want 0/0/0/0/0",
               sta, depth, full, ovf, unf);
    end
    Clrn = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_wsta();
    step(0, 0, 1, 0, 32'h0000_00FF);
    checks++;
    if (sta !== 32'h0000_00FF || depth !== 3'd0) begin
      errors++;
      $display("FAIL wsta: sta=%h depth=%0d, want 000000ff/0", sta, depth);
    end
  endtask

  task automatic test_exc_eret();
    step(0, 0, 1, 0, 32'hA5A5_A5AF);
    step(1, 0, 0, 0, '0);
    checks++;
    if (sta !== 32'hA5A5_A5A0 || depth !== 3'd1) begin
      errors++;
      $display("FAIL exc_mask: sta=%h depth=%0d, want a5a5a5a0/1", sta, depth);
    end
    step(0, 1, 0, 0, '0);
    checks++;
    if (sta !== 32'hA5A5_A5AF || depth !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      errors++;
      $display("FAIL eret_restore: sta=%h depth=%0d ovf=%b unf=%b, want a5a5a5af/0/0/0",
               sta, depth, ovf, unf);
    end
  endtask

  task automatic test_nesting();
    logic [2:0]  exp_depth;
    logic [31:0] exp_sta;
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 0, 32'h1234_5670 | 32'(i));
      step(1, 0, 0, 0, '0);
      exp_depth = (i > 4) ? 3'd4 : 3'(i);
      checks++;
      if (depth !== exp_depth || sta !== 32'h1234_5670) begin
        errors++;
        $display("FAIL nest_push%0d: depth=%0d sta=%h, want %0d/12345670", i, depth, sta, exp_depth);
      end
    end
    checks++;
    if (full !== 1'b1 || ovf !== 1'b1 || unf !== 1'b0) begin
      errors++;
      $display("FAIL nest_full: full=%b ovf=%b unf=%b, want 1/1/0", full, ovf, unf);
    end
    for (int i = 4; i >= 1; i--) begin
      step(0, 1, 0, 0, '0);
      exp_sta   = 32'h1234_5670 | 32'(i);
      exp_depth = 3'(i - 1);
      checks++;
      if (sta !== exp_sta || depth !== exp_depth || full !== 1'b0) begin
        errors++;
        $display("FAIL nest_pop%0d: sta=%h depth=%0d full=%b, want %h/%0d/0",
                 i, sta, depth, full, exp_sta, exp_depth);
      end
    end
    step(0, 1, 0, 0, '0);
    checks++;
    if (unf !== 1'b1 || sta !== 32'h1234_5671 || depth !== 3'd0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL nest_underflow: unf=%b sta=%h depth=%0d ovf=%b, want 1/12345671/0/1",
               unf, sta, depth, ovf);
    end
  endtask

  task automatic test_clr_err();
    step(0, 0, 0, 1, '0);
    checks++;
    if (ovf !== 1'b0 || unf !== 1'b0 || sta !== 32'h1234_5671) begin
      errors++;
      $display("FAIL clr_alone: ovf=%b unf=%b sta=%h, want 0/0/12345671", ovf, unf, sta);
    end
    step(0, 1, 0, 1, '0);
    checks++;
    if (unf !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_vs_unf: unf=%b ovf=%b, want 1/0", unf, ovf);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, '0);
    step(1, 0, 0, 1, '0);
    checks++;
    if (ovf !== 1'b1 || depth !== 3'd4) begin
      errors++;
      $display("FAIL clr_vs_ovf: ovf=%b depth=%0d, want 1/4", ovf, depth);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, '0);
    step(0, 0, 0, 1, '0);
  endtask

  task automatic test_collision();
    step(0, 0, 1, 0, 32'h0000_000F);
    step(1, 1, 1, 0, 32'hDEAD_BEEF);
    checks++;
    if (sta !== 32'h0 || depth !== 3'd1 || unf !== 1'b0) begin
      errors++;
      $display("FAIL coll_all: sta=%h depth=%0d unf=%b, want 0/1/0", sta, depth, unf);
    end
    step(0, 0, 1, 0, 32'h0000_0077);
    step(0, 1, 1, 0, 32'h0000_0099);
    checks++;
    if (sta !== 32'h0000_000F || depth !== 3'd0) begin
      errors++;
      $display("FAIL coll_eret_wsta: sta=%h depth=%0d, want 0000000f/0", sta, depth);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 1, 0, 32'h0000_00AB);
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    checks++;
    if (sta !== 32'h0000_00A0 || depth !== 3'd2) begin
      errors++;
      $display("FAIL b2b_push: sta=%h depth=%0d, want 000000a0/2", sta, depth);
    end
    step(0, 1, 0, 0, '0);
    checks++;
    if (sta !== 32'h0000_00A0 || depth !== 3'd1) begin
      errors++;
      $display("FAIL b2b_pop1: sta=%h depth=%0d, want 000000a0/1", sta, depth);
    end
    step(0, 1, 0, 0, '0);
    checks++;
    if (sta !== 32'h0000_00AB || depth !== 3'd0) begin
      errors++;
      $display("FAIL b2b_pop2: sta=%h depth=%0d, want 000000ab/0", sta, depth);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 0, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0);
    checks++;
    if (depth !== 3'd3 || sta !== 32'hCAFE_F000) begin
      errors++;
      $display("FAIL pre_reset: depth=%0d sta=%h, want 3/cafef000", depth, sta);
    end
    @(posedge Clk);
    #2 Clrn = 1'b0;
    #1;
    checks++;
    if (sta !== 32'h0 || depth !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: sta=%h depth=%0d ovf=%b unf=%b, want 0/0/0/0", sta, depth, ovf, unf);
    end
    @(negedge Clk);
    Clrn = 1'b1;
    step(0, 1, 0, 0, '0);
    checks++;
    if (unf !== 1'b1 || depth !== 3'd0 || sta !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_eret: unf=%b depth=%0d sta=%h, want 1/0/0", unf, depth, sta);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_wsta();
    test_exc_eret();
    test_nesting();
    test_clr_err();
    test_collision();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
